// File: rtl/data_mem.sv
// Word-organised data memory with byte-lane stores, extended loads, a post-reset
// zeroing sweep and misalignment/range error flags.
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [1:0]  StoreSRC,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  LoadSRC,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        MisalignErr,
    output logic        ErrSticky
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   init_ptr_q, init_ptr_d;
    logic            err_q, err_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [AW-1:0]   word_idx;
    logic [1:0]      offset;
    logic            out_of_range;
    logic [1:0]      chk_size;
    logic            misaligned;
    logic            ld_bad;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;

    assign word_idx     = ALUResult[AW+1:2];
    assign offset       = ALUResult[1:0];
    assign out_of_range = |ALUResult[31:AW+2];
    assign Ready        = (state_q == S_READY);
    assign ErrSticky    = err_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            err_q      <= err_d;
        end
    end

    // Next state: sweep every word once, then serve accesses
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        err_d      = err_q | MisalignErr;
        if (state_q == S_INIT) begin
            init_ptr_d = AW'(init_ptr_q + 1'b1);
            if (init_ptr_q == LAST_IDX) begin
                state_d = S_READY;
            end
        end
    end

    // Access checking; size comes from the store when writing, else from the load
    always_comb begin
        chk_size    = MemWrite ? StoreSRC : LoadSRC[1:0];
        misaligned  = ((chk_size == 2'b01) && offset[0]) ||
                      ((chk_size == 2'b10) && (offset != 2'b00));
        MisalignErr = Ready && (MemWrite || MemRead) && (misaligned || out_of_range);
    end

    // Outputs of the FSM: the single memory write port
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_be   = 4'b0000;
        wr_data = WriteData;
        if (state_q == S_INIT) begin
            wr_en   = rst_n;
            wr_idx  = init_ptr_q;
            wr_be   = 4'b1111;
            wr_data = '0;
        end else if (rst_n && MemWrite && (StoreSRC != 2'b11) && !MisalignErr) begin
            wr_en = 1'b1;
            case (StoreSRC)
                2'b00: begin
                    wr_be   = 4'(4'b0001 << offset);
                    wr_data = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    wr_be   = offset[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{WriteData[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = WriteData;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) begin
                    mem_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
                end
            end
        end
    end

    // Load path: lane select then extend; bad or invalid loads return zero
    always_comb begin
        rd_word  = mem_q[word_idx];
        rd_byte  = rd_word[{offset, 3'b000} +: 8];
        rd_half  = rd_word[{offset[1], 4'b0000} +: 16];
        ld_bad   = out_of_range ||
                   ((LoadSRC[1:0] == 2'b01) && offset[0]) ||
                   ((LoadSRC[1:0] == 2'b10) && (offset != 2'b00));
        ReadData = '0;
        if (Ready && !ld_bad) begin
            case (LoadSRC)
                3'b000:  ReadData = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  ReadData = {{16{rd_half[15]}}, rd_half};
                3'b010:  ReadData = rd_word;
                3'b100:  ReadData = {24'b0, rd_byte};
                3'b101:  ReadData = {16'b0, rd_half};
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem (16 words): byte-array reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_data_mem;

    localparam int DEPTH = 16;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [1:0]  StoreSRC;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  LoadSRC;
    logic [31:0] ReadData;
    logic        Ready;
    logic        MisalignErr;
    logic        ErrSticky;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ALUResult(ALUResult), .WriteData(WriteData),
        .StoreSRC(StoreSRC), .MemWrite(MemWrite), .MemRead(MemRead), .LoadSRC(LoadSRC),
        .ReadData(ReadData), .Ready(Ready), .MisalignErr(MisalignErr), .ErrSticky(ErrSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_bytes [NBYTES];
    bit         m_valid  = 0;
    bit         m_ready  = 0;
    bit         m_sticky = 0;
    int         m_cnt    = 0;

    function automatic int size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit exp_err();
        int n;
        if (!m_ready || !(MemWrite || MemRead)) return 0;
        n = size_of(MemWrite ? StoreSRC : LoadSRC[1:0]);
        return (ALUResult >= 32'(NBYTES)) || ((ALUResult % 32'(n)) != 0);
    endfunction

    function automatic logic [31:0] exp_rd();
        int n;
        bit sgn;
        logic [31:0] v;
        int a;
        if (!m_ready) return 32'd0;
        case (LoadSRC)
            3'b000:  begin n = 1; sgn = 1; end
            3'b001:  begin n = 2; sgn = 1; end
            3'b010:  begin n = 4; sgn = 0; end
            3'b100:  begin n = 1; sgn = 0; end
            3'b101:  begin n = 2; sgn = 0; end
            default: return 32'd0;
        endcase
        if (ALUResult >= 32'(NBYTES) || (ALUResult % 32'(n)) != 0) return 32'd0;
        a = int'(ALUResult);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | ({24'd0, m_bytes[a + k]} << (8 * k));
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // Model update at each clock edge, using the pre-edge state
    always @(posedge clk) begin
        bit e;
        int n;
        int a;
        if (!rst_n) begin
            m_valid  = 1;
            m_ready  = 0;
            m_cnt    = 0;
            m_sticky = 0;
        end else if (m_valid) begin
            e = exp_err();
            if (m_ready) begin
                if (e) m_sticky = 1;
                if (MemWrite && StoreSRC != 2'b11 && !e) begin
                    n = size_of(StoreSRC);
                    a = int'(ALUResult);
                    for (int k = 0; k < n; k++) m_bytes[a + k] = WriteData[8*k +: 8];
                end
            end else begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_ready = 1;
                    for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_ready",    32'(Ready),       32'(m_ready));
            check("cyc_sticky",   32'(ErrSticky),   32'(m_sticky));
            check("cyc_misalign", 32'(MisalignErr), 32'(exp_err()));
            check("cyc_readdata", ReadData,         exp_rd());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ALUResult = 32'd0;
        WriteData = 32'd0;
        StoreSRC  = 2'b11;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        LoadSRC   = 3'b011;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] src);
        ALUResult = addr;
        WriteData = data;
        StoreSRC  = src;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        LoadSRC   = 3'b010;
        step();
        idle();
    endtask

    task automatic load(input string name, input logic [31:0] addr, input logic [2:0] ls,
                        input logic [31:0] exp);
        ALUResult = addr;
        LoadSRC   = ls;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        #1;
        check(name, ReadData, exp);
        step();
        idle();
    endtask

    task automatic wait_ready(input string name);
        int cyc;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!Ready && cyc < 100);
        check(name, 32'(cyc), 32'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        check("reset_ready",  32'(Ready),     32'd0);
        check("reset_sticky", 32'(ErrSticky), 32'd0);
        check("reset_rd",     ReadData,       32'd0);

        // Sweep interrupted at cycle 5, with stores attempted throughout INIT
        rst_n     = 1'b1;
        ALUResult = 32'h2;
        WriteData = 32'hDEADBEEF;
        StoreSRC  = 2'b10;
        MemWrite  = 1'b1;
        repeat (5) step();
        check("init_misalign", 32'(MisalignErr), 32'd0);
        check("init_rd",       ReadData,         32'd0);
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        ALUResult = 32'h4;
        wait_ready("ready_latency_restart");
        idle();
        check("init_sticky", 32'(ErrSticky), 32'd0);

        for (int i = 0; i < DEPTH; i++) load("init_zero", 32'(4 * i), 3'b010, 32'd0);

        // Byte store
        store(32'h5, 32'h000000AB, 2'b00);
        load("lw_4",  32'h4, 3'b010, 32'h0000AB00);
        load("lb_5",  32'h5, 3'b000, 32'hFFFFFFAB);
        load("lbu_5", 32'h5, 3'b100, 32'h000000AB);
        load("lb_4",  32'h4, 3'b000, 32'h00000000);

        // Word then half
        store(32'h8, 32'h11223344, 2'b10);
        store(32'hA, 32'h00008001, 2'b01);
        load("lw_8",   32'h8, 3'b010, 32'h80013344);
        load("lh_a",   32'hA, 3'b001, 32'hFFFF8001);
        load("lhu_a",  32'hA, 3'b101, 32'h00008001);
        load("lh_8",   32'h8, 3'b001, 32'h00003344);
        load("lb_b",   32'hB, 3'b000, 32'hFFFFFF80);
        load("inv_ls", 32'h8, 3'b110, 32'h00000000);

        // Misaligned word store
        ALUResult = 32'h2;
        WriteData = 32'h55555555;
        StoreSRC  = 2'b10;
        MemWrite  = 1'b1;
        #1;
        check("sw_2_err",    32'(MisalignErr), 32'd1);
        check("sw_2_sticky", 32'(ErrSticky),   32'd0);
        step();
        idle();
        check("sticky_set", 32'(ErrSticky), 32'd1);
        load("sw_2_nowrite", 32'h0, 3'b010, 32'h00000000);
        repeat (3) step();
        check("sticky_hold", 32'(ErrSticky), 32'd1);

        // Misaligned half load
        ALUResult = 32'h3;
        LoadSRC   = 3'b001;
        MemRead   = 1'b1;
        #1;
        check("lh_3_err", 32'(MisalignErr), 32'd1);
        check("lh_3_rd",  ReadData,         32'd0);
        step();
        idle();

        // Out-of-range store must not alias into word 0
        ALUResult = 32'h40;
        WriteData = 32'h77777777;
        StoreSRC  = 2'b10;
        MemWrite  = 1'b1;
        #1;
        check("sw_40_err", 32'(MisalignErr), 32'd1);
        step();
        idle();
        load("sw_40_nowrite", 32'h0,  3'b010, 32'h00000000);
        load("lw_40",         32'h40, 3'b010, 32'h00000000);

        // Read during write shows old data until the edge
        ALUResult = 32'h10;
        WriteData = 32'hCAFEF00D;
        StoreSRC  = 2'b10;
        MemWrite  = 1'b1;
        LoadSRC   = 3'b010;
        #1;
        check("rdw_old", ReadData, 32'h00000000);
        step();
        MemWrite = 1'b0;
        #1;
        check("rdw_new", ReadData, 32'hCAFEF00D);
        idle();
        step();

        // Suppressed store
        ALUResult = 32'h8;
        WriteData = 32'hFFFFFFFF;
        StoreSRC  = 2'b11;
        MemWrite  = 1'b1;
        step();
        idle();
        load("nostore_8", 32'h8, 3'b010, 32'h80013344);

        // Reset from READY clears sticky and memory
        rst_n = 1'b0;
        step();
        check("rst2_ready",  32'(Ready),     32'd0);
        check("rst2_sticky", 32'(ErrSticky), 32'd0);
        rst_n = 1'b1;
        wait_ready("ready_latency_rerun");
        for (int i = 0; i < DEPTH; i++) load("reinit_zero", 32'(4 * i), 3'b010, 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
